// File: rtl/frame_mem_arbiter.sv
// Arbitrates one single-port frame memory: display reads win, camera writes are posted to a FIFO and drained in spare cycles.
// Optional statistics counters are built only when FRAME_ARB_STATS_EN is defined.
module frame_mem_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 16,
  parameter int WBUF_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_wr_valid,
  output logic              cam_wr_ready,
  input  logic [ADDR_W-1:0] cam_wr_addr,
  input  logic [DATA_W-1:0] cam_wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err_rd_overrun,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stat_wr_stall_cnt,
  output logic [15:0]       stat_forced_cnt
);

  localparam int PTR_W    = $clog2(WBUF_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]    DEPTH_C    = CNT_W'(WBUF_DEPTH);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {GNT_NONE, GNT_RD, GNT_WR} gnt_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  wr_entry_t               fifo_mem [WBUF_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    rd_pend;
  logic [ADDR_W-1:0]       rd_pend_addr;
  logic [STARVE_W-1:0]     starve_cnt;
  logic                    rd_stage;

  logic                    push;
  logic                    fifo_empty;
  logic                    fifo_wr;
  logic                    fifo_rd;
  logic                    wr_cand;
  logic                    rd_cand;
  logic [ADDR_W-1:0]       rd_issue_addr;
  wr_entry_t               wr_head;
  gnt_e                    gnt;

  assign cam_wr_ready  = (count < DEPTH_C) && !reset;
  assign push          = cam_wr_valid && cam_wr_ready;
  assign fifo_empty    = (count == '0);
  // A push into an empty buffer is offered straight to the memory so an idle arbiter writes next cycle.
  assign wr_cand       = !fifo_empty || push;
  assign wr_head       = fifo_empty ? wr_entry_t'{addr: cam_wr_addr, data: cam_wr_data} : fifo_mem[rd_ptr];
  assign rd_cand       = rd_pend || rd_req;
  assign rd_issue_addr = rd_pend ? rd_pend_addr : rd_addr;
  assign fifo_wr       = push && !(gnt == GNT_WR && fifo_empty);
  assign fifo_rd       = (gnt == GNT_WR) && !fifo_empty;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    gnt = GNT_NONE;
    if (rd_cand && wr_cand) begin
      gnt = (starve_cnt == STARVE_MAX) ? GNT_WR : GNT_RD;
    end else if (rd_cand) begin
      gnt = GNT_RD;
    end else if (wr_cand) begin
      gnt = GNT_WR;
    end
  end

  // NOTE: the buffer storage carries no reset; only pointers and count need one to make it empty.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr] <= wr_entry_t'{addr: cam_wr_addr, data: cam_wr_data};
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Pending read, overrun flag and writer starvation tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend        <= 1'b0;
      rd_pend_addr   <= '0;
      err_rd_overrun <= 1'b0;
      starve_cnt     <= '0;
    end else begin
      if (gnt == GNT_RD) begin
        // Issuing the older pending read lets a same-cycle request take its place.
        rd_pend <= rd_pend && rd_req;
        if (rd_pend && rd_req) rd_pend_addr <= rd_addr;
      end else if (rd_req && !rd_pend) begin
        rd_pend      <= 1'b1;
        rd_pend_addr <= rd_addr;
      end else if (rd_req) begin
        err_rd_overrun <= 1'b1;
      end

      if (gnt == GNT_WR || !wr_cand) begin
        starve_cnt <= '0;
      end else if (rd_cand && starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

  // Registered memory command and two-stage read return.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_stage  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      case (gnt)
        GNT_RD: begin
          mem_en   <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= rd_issue_addr;
        end
        GNT_WR: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= wr_head.addr;
          mem_wdata <= wr_head.data;
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
      rd_stage <= mem_en && !mem_we;
      rd_valid <= rd_stage;
      if (rd_stage) rd_data <= mem_rdata;
    end
  end

`ifdef FRAME_ARB_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] forced_q;
  logic        forced;

  assign forced = (gnt == GNT_WR) && rd_cand;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      forced_q <= '0;
    end else begin
      if (cam_wr_valid && !cam_wr_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (forced && forced_q != 16'hFFFF) forced_q <= forced_q + 16'd1;
    end
  end

  assign stat_wr_stall_cnt = stall_q;
  assign stat_forced_cnt   = forced_q;
`else
  assign stat_wr_stall_cnt = '0;
  assign stat_forced_cnt   = '0;
`endif

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter: a synchronous memory model plus write/read scoreboards and cycle-exact checks.
module tb_frame_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cam_wr_valid;
  logic        cam_wr_ready;
  logic [16:0] cam_wr_addr;
  logic [15:0] cam_wr_data;
  logic        rd_req;
  logic [16:0] rd_addr;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        err_rd_overrun;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] stat_wr_stall_cnt;
  logic [15:0] stat_forced_cnt;

  int errors = 0;
  int checks = 0;
  logic [32:0] wq[$];
  logic [15:0] rq[$];

`ifdef FRAME_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  frame_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cam_wr_valid(cam_wr_valid), .cam_wr_ready(cam_wr_ready),
    .cam_wr_addr(cam_wr_addr), .cam_wr_data(cam_wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .err_rd_overrun(err_rd_overrun),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_wr_stall_cnt(stat_wr_stall_cnt), .stat_forced_cnt(stat_forced_cnt)
  );

  // Memory contents seen by reads; reads and writes in this bench never touch the same address.
  function automatic logic [15:0] init_word(input logic [16:0] a);
    return (a == 17'h00100) ? 16'hF800 : (a[15:0] ^ 16'h3C3C);
  endfunction

  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= init_word(mem_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every memory write and every returned pixel must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_en && mem_we) begin
        chk("wr_sb_nonempty", 64'(wq.size() != 0), 64'd1);
        if (wq.size() != 0) chk("wr_sb_addr_data", 64'({mem_addr, mem_wdata}), 64'(wq.pop_front()));
      end
      if (rd_valid) begin
        chk("rd_sb_nonempty", 64'(rq.size() != 0), 64'd1);
        if (rq.size() != 0) chk("rd_sb_data", 64'(rd_data), 64'(rq.pop_front()));
      end
    end
  end

  // Drives one cycle of stimulus, records accepted writes and expected reads, returns mid next cycle.
  task automatic step(input logic rq_i, input logic [16:0] ra, input logic wv,
                      input logic [16:0] wa, input logic [15:0] wd, input logic expect_rd,
                      output logic accepted);
    rd_req       = rq_i;
    rd_addr      = ra;
    cam_wr_valid = wv;
    cam_wr_addr  = wa;
    cam_wr_data  = wd;
    #1;
    accepted = wv && cam_wr_ready;
    if (accepted) wq.push_back({wa, wd});
    if (rq_i && expect_rd) rq.push_back(init_word(ra));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0, acc);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_mem_en"}, 64'(mem_en), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, "_err"}, 64'(err_rd_overrun), 64'd0);
    chk({tag, "_stall"}, 64'(stat_wr_stall_cnt), 64'd0);
    chk({tag, "_forced"}, 64'(stat_forced_cnt), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    int   wi;

    reset = 1'b1;
    rd_req = 1'b0; rd_addr = '0;
    cam_wr_valid = 1'b0; cam_wr_addr = '0; cam_wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready_low", 64'(cam_wr_ready), 64'd0);
    chk_reset_values("rst");
    reset = 1'b0;
    #1;
    chk("rst_ready_high", 64'(cam_wr_ready), 64'd1);
    @(negedge clk);

    // Isolated read.
    step(1'b1, 17'h00100, 1'b0, '0, '0, 1'b1, acc);
    chk("rd1_mem_en", 64'(mem_en), 64'd1);
    chk("rd1_mem_we", 64'(mem_we), 64'd0);
    chk("rd1_mem_addr", 64'(mem_addr), 64'h100);
    idle(1);
    chk("rd1_valid_c2", 64'(rd_valid), 64'd0);
    idle(1);
    chk("rd1_valid_c3", 64'(rd_valid), 64'd1);
    chk("rd1_data", 64'(rd_data), 64'hF800);

    // Write burst into an idle arbiter: each push reaches the memory the next cycle.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 17'(i), 16'hA000 + 16'(i), 1'b0, acc);
      chk("burst_accept", 64'(acc), 64'd1);
      chk("burst_mem_we", 64'({mem_en, mem_we}), 64'b11);
      chk("burst_addr", 64'(mem_addr), 64'(i));
      chk("burst_data", 64'(mem_wdata), 64'(16'hA000 + 16'(i)));
    end
    idle(1);
    chk("burst_idle_after", 64'(mem_en), 64'd0);
    idle(2);

    // Starvation: the write pushed with the first read makes that cycle the first conflict.
    step(1'b1, 17'h00400, 1'b1, 17'h02000, 16'hB000, 1'b1, acc);
    chk("starve_push", 64'(acc), 64'd1);
    for (int c = 1; c < 8; c++) begin
      step(1'b1, 17'h00400 + 17'(c), 1'b0, '0, '0, 1'b1, acc);
      chk("starve_read_wins", 64'({mem_en, mem_we}), 64'b10);
    end
    step(1'b1, 17'h00408, 1'b0, '0, '0, 1'b1, acc);
    chk("starve_forced_we", 64'({mem_en, mem_we}), 64'b11);
    chk("starve_forced_addr", 64'(mem_addr), 64'h2000);
    idle(1);
    chk("starve_deferred_rd", 64'({mem_en, mem_we}), 64'b10);
    chk("starve_deferred_addr", 64'(mem_addr), 64'h408);
    idle(1);
    chk("starve_valid_c3", 64'(rd_valid), 64'd0);
    idle(1);
    chk("starve_valid_c4", 64'(rd_valid), 64'd1);
    chk("starve_data", 64'(rd_data), 64'(init_word(17'h00408)));
    chk("starve_forced_cnt", 64'(stat_forced_cnt), STATS ? 64'd1 : 64'd0);
    idle(3);

    // Buffer full then overrun: reads every cycle, five writes offered back to back.
    wi = 0;
    for (int c = 0; c < 18; c++) begin
      if (c == 17) chk("ovr_err_before", 64'(err_rd_overrun), 64'd0);
      step(1'b1, 17'h00500 + 17'(c), wi < 5, 17'h03000 + 17'(wi), 16'hC000 + 16'(wi), c != 17, acc);
      if (c == 4) chk("full_ready_low", 64'(acc), 64'd0);
      if (c == 8) chk("full_still_held", 64'(acc), 64'd0);
      if (c == 9) chk("full_fifth_accepted", 64'(acc), 64'd1);
      if (acc) wi++;
    end
    chk("ovr_err_set", 64'(err_rd_overrun), 64'd1);
    idle(8);
    chk("ovr_err_held", 64'(err_rd_overrun), 64'd1);
    chk("drain_writes_done", 64'(wq.size()), 64'd0);
    chk("drain_reads_done", 64'(rq.size()), 64'd0);
    chk("full_stall_cnt", 64'(stat_wr_stall_cnt), STATS ? 64'd5 : 64'd0);
    chk("full_forced_cnt", 64'(stat_forced_cnt), STATS ? 64'd3 : 64'd0);

    // Reset one cycle after a read issue: nothing in flight or buffered may survive.
    step(1'b1, 17'h00600, 1'b1, 17'h04000, 16'hD000, 1'b0, acc);
    step(1'b1, 17'h00601, 1'b1, 17'h04001, 16'hD001, 1'b0, acc);
    wq.delete();
    rq.delete();
    reset = 1'b1;
    rd_req = 1'b0;
    cam_wr_valid = 1'b0;
    #1;
    chk("mid_rst_ready_low", 64'(cam_wr_ready), 64'd0);
    @(negedge clk);
    chk("mid_rst_no_valid", 64'(rd_valid), 64'd0);
    @(negedge clk);
    chk("mid_rst_no_valid2", 64'(rd_valid), 64'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready_high", 64'(cam_wr_ready), 64'd1);
    chk_reset_values("mid_rst");
    @(negedge clk);
    idle(6);
    chk("mid_rst_mem_idle", 64'(mem_en), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
